m_bpred_btb: RTL and testbench

//  Parametrised branch target buffer with per-entry saturating direction counters, LRU replacement.

---
 rtl/m_bpred_btb_pkg.sv | 30 +++
 rtl/m_bpred_btb_if.sv | 32 +++
 rtl/m_bpred_cam.sv | 29 ++
 rtl/m_bpred_btb.sv | 128 ++++++++++++
 tb/tb_m_bpred_btb.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/m_bpred_btb_pkg.sv
// Shared constants and helpers for the branch target buffer: stat width,
// entry range limits, weak counter initial values and the update classification.
package m_bpred_btb_pkg;

    localparam int STAT_W      = 32;
    localparam int MIN_ENTRIES = 2;
    localparam int MAX_ENTRIES = 16;
    localparam int MAX_CNT_W   = 4;

    typedef enum logic [1:0] {
        UPD_NONE,
        UPD_HIT,
        UPD_ALLOC,
        UPD_SKIP
    } upd_kind_e;

    // Weakly-taken is the counter midpoint; weakly-not-taken sits one below it.
    function automatic logic [MAX_CNT_W-1:0] cnt_weak_t(input int cnt_w);
        return MAX_CNT_W'(1) << (cnt_w - 1);
    endfunction

    function automatic logic [MAX_CNT_W-1:0] cnt_weak_nt(input int cnt_w);
        return cnt_weak_t(cnt_w) - MAX_CNT_W'(1);
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/m_bpred_btb_if.sv
// Pipeline-facing bundle of the branch target buffer: EX-stage update port,
// IF-stage lookup port, flush and statistics.
interface m_bpred_btb_if
    import m_bpred_btb_pkg::*;
#(
    parameter int ADDR_W = 11
) ();

    logic              w_flush;
    logic              w_be;
    logic [ADDR_W-1:0] w_baddr;
    logic              w_br;
    logic [ADDR_W-1:0] w_bdst;
    logic              w_bmis;
    logic [ADDR_W-1:0] w_paddr;
    logic              w_pre;
    logic              w_pr;
    logic [ADDR_W-1:0] w_pdst;
    logic [STAT_W-1:0] r_nupd;
    logic [STAT_W-1:0] r_nmis;

    modport master (
        output w_flush, w_be, w_baddr, w_br, w_bdst, w_bmis, w_paddr,
        input  w_pre, w_pr, w_pdst, r_nupd, r_nmis
    );

    modport slave (
        input  w_flush, w_be, w_baddr, w_br, w_bdst, w_bmis, w_paddr,
        output w_pre, w_pr, w_pdst, r_nupd, r_nmis
    );

endinterface

// File: rtl/m_bpred_cam.sv
// Fully-associative match of one address against all valid tags;
// reports a hit and the lowest matching slot index.
module m_bpred_cam
    import m_bpred_btb_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int ADDR_W  = 11,
    parameter int IDX_W   = 2
) (
    input  logic [ADDR_W-1:0]  key,
    input  logic [ADDR_W-1:0]  tag [ENTRIES],
    input  logic [ENTRIES-1:0] valid,
    output logic               hit,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top down so the lowest matching slot is the last writer.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && (tag[i] == key)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/m_bpred_btb.sv
// Branch target buffer: combinational IF lookup, EX update with saturating
// direction counters, true-LRU replacement, flush and update statistics.
module m_bpred_btb
    import m_bpred_btb_pkg::*;
#(
    parameter int ENTRIES  = 4,
    parameter int ADDR_W   = 11,
    parameter int CNT_W    = 2,
    parameter int ALLOC_NT = 1
) (
    input logic          w_clk,
    input logic          w_rst_n,
    m_bpred_btb_if.slave bus
);

    localparam int               IDX_W   = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(cnt_weak_t(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_weak_nt(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W-1:0] AGE_OLD = IDX_W'(ENTRIES - 1);

    logic [ENTRIES-1:0] valid_q;
    logic [ADDR_W-1:0]  tag_q [ENTRIES];
    logic [ADDR_W-1:0]  dst_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q [ENTRIES];
    logic [IDX_W-1:0]   age_q [ENTRIES];
    logic [STAT_W-1:0]  nupd_q;
    logic [STAT_W-1:0]  nmis_q;

    logic               p_hit;
    logic               u_hit;
    logic [IDX_W-1:0]   p_idx;
    logic [IDX_W-1:0]   u_idx;
    logic [IDX_W-1:0]   victim;
    logic [IDX_W-1:0]   touch;
    upd_kind_e          upd_kind;

    m_bpred_cam #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_cam_lookup (
        .key   (bus.w_paddr),
        .tag   (tag_q),
        .valid (valid_q),
        .hit   (p_hit),
        .idx   (p_idx)
    );

    m_bpred_cam #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_cam_update (
        .key   (bus.w_baddr),
        .tag   (tag_q),
        .valid (valid_q),
        .hit   (u_hit),
        .idx   (u_idx)
    );

    assign bus.w_pre  = p_hit;
    assign bus.w_pr   = p_hit & cnt_q[p_idx][CNT_W-1];
    assign bus.w_pdst = p_hit ? dst_q[p_idx] : '0;
    assign bus.r_nupd = nupd_q;
    assign bus.r_nmis = nmis_q;

    // Free slots are preferred over evicting the oldest one.
    always_comb begin
        victim = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (age_q[i] == AGE_OLD) victim = IDX_W'(i);
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) victim = IDX_W'(i);
        end

        upd_kind = UPD_NONE;
        if (bus.w_be && !bus.w_flush) begin
            if (u_hit)                          upd_kind = UPD_HIT;
            else if (ALLOC_NT != 0 || bus.w_br) upd_kind = UPD_ALLOC;
            else                                upd_kind = UPD_SKIP;
        end
        touch = (upd_kind == UPD_HIT) ? u_idx : victim;
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            valid_q <= '0;
            nupd_q  <= '0;
            nmis_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                dst_q[i] <= '0;
                cnt_q[i] <= CNT_WNT;
                age_q[i] <= IDX_W'(i);
            end
        end else begin
            if (bus.w_flush) valid_q <= '0;

            if (bus.w_be) begin
                nupd_q <= sat_inc(nupd_q);
                if (bus.w_bmis) nmis_q <= sat_inc(nmis_q);
            end

            case (upd_kind)
                UPD_HIT: begin
                    if (bus.w_br) begin
                        if (cnt_q[touch] != CNT_MAX) cnt_q[touch] <= cnt_q[touch] + CNT_W'(1);
                        dst_q[touch] <= bus.w_bdst;
                    end else if (cnt_q[touch] != '0) begin
                        cnt_q[touch] <= cnt_q[touch] - CNT_W'(1);
                    end
                end
                UPD_ALLOC: begin
                    valid_q[touch] <= 1'b1;
                    tag_q[touch]   <= bus.w_baddr;
                    dst_q[touch]   <= bus.w_bdst;
                    cnt_q[touch]   <= bus.w_br ? CNT_WT : CNT_WNT;
                end
                default: ;
            endcase

            // Touched slot becomes youngest; only slots younger than it age.
            if (upd_kind == UPD_HIT || upd_kind == UPD_ALLOC) begin
                for (int j = 0; j < ENTRIES; j++) begin
                    if (IDX_W'(j) == touch)
                        age_q[j] <= '0;
                    else if (age_q[j] < age_q[touch])
                        age_q[j] <= age_q[j] + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_m_bpred_btb.sv
// Scoreboard bench for m_bpred_btb (4 entries, 2-bit counters, taken-only allocation):
// stimulus queues expected lookups/stats per cycle, a negedge monitor compares them.
module tb_m_bpred_btb;
    import m_bpred_btb_pkg::*;

    localparam int ADDR_W = 11;

    typedef struct {
        string             name;
        bit                isStats;
        logic              pre;
        logic              pr;
        logic [ADDR_W-1:0] pdst;
        logic [31:0]       nupd;
        logic [31:0]       nmis;
        int                cyc;
    } expect_t;

    logic    w_clk   = 1'b0;
    logic    w_rst_n = 1'b0;
    int      cyc     = 0;
    int      checks  = 0;
    int      errors  = 0;
    expect_t expQ[$];
    expect_t curExp;

    m_bpred_btb_if #(.ADDR_W(ADDR_W)) bus ();

    m_bpred_btb #(.ENTRIES(4), .ADDR_W(ADDR_W), .CNT_W(2), .ALLOC_NT(0)) dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .bus     (bus)
    );

    always #5 w_clk = ~w_clk;

    always @(posedge w_clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic be, input logic [ADDR_W-1:0] baddr, input logic br,
                                 input logic [ADDR_W-1:0] bdst, input logic bmis, input logic flush,
                                 input logic [ADDR_W-1:0] paddr);
        @(posedge w_clk);
        #1;
        bus.w_be    = be;
        bus.w_baddr = baddr;
        bus.w_br    = br;
        bus.w_bdst  = bdst;
        bus.w_bmis  = bmis;
        bus.w_flush = flush;
        bus.w_paddr = paddr;
    endtask

    task automatic look(input logic [ADDR_W-1:0] paddr);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, paddr);
    endtask

    task automatic expectLookup(input string name, input logic pre, input logic pr,
                                input logic [ADDR_W-1:0] pdst);
        expect_t e;
        e.name = name; e.isStats = 1'b0; e.pre = pre; e.pr = pr; e.pdst = pdst;
        e.nupd = '0; e.nmis = '0; e.cyc = cyc;
        expQ.push_back(e);
    endtask

    task automatic expectStats(input string name, input logic [31:0] nupd, input logic [31:0] nmis);
        expect_t e;
        e.name = name; e.isStats = 1'b1; e.pre = 1'b0; e.pr = 1'b0; e.pdst = '0;
        e.nupd = nupd; e.nmis = nmis; e.cyc = cyc;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input expect_t e);
        checks++;
        if (e.cyc != cyc) begin
            errors++;
            $display("[TB] FAIL %s: checked in cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
        end else if (e.isStats) begin
            if (bus.r_nupd !== e.nupd || bus.r_nmis !== e.nmis) begin
                errors++;
                $display("[TB] FAIL %s: nupd=%0d nmis=%0d, required nupd=%0d nmis=%0d",
                         e.name, bus.r_nupd, bus.r_nmis, e.nupd, e.nmis);
            end
        end else if (bus.w_pre !== e.pre || bus.w_pr !== e.pr || bus.w_pdst !== e.pdst) begin
            errors++;
            $display("[TB] FAIL %s: pre=%b pr=%b pdst=%h, required pre=%b pr=%b pdst=%h",
                     e.name, bus.w_pre, bus.w_pr, bus.w_pdst, e.pre, e.pr, e.pdst);
        end
    endtask

    always @(negedge w_clk) begin
        while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            curExp = expQ.pop_front();
            checkOutput(curExp);
        end
    end

    initial begin
        bus.w_be = 1'b0; bus.w_baddr = '0; bus.w_br = 1'b0; bus.w_bdst = '0;
        bus.w_bmis = 1'b0; bus.w_flush = 1'b0; bus.w_paddr = 11'h010;
        repeat (2) @(posedge w_clk);
        #1 w_rst_n = 1'b1;

        // reset state
        look(11'h010);                                      expectLookup("reset_lookup", 0, 0, '0);
        expectStats("reset_stats", 0, 0);

        // first allocation, no same-cycle bypass
        applyStimulus(1, 11'h010, 1, 11'h004, 0, 0, 11'h010); expectLookup("same_cycle_no_bypass", 0, 0, '0);
        look(11'h010);                                      expectLookup("alloc_visible", 1, 1, 11'h004);
        expectStats("first_update_count", 1, 0);

        // counter saturation both ways
        applyStimulus(1, 11'h010, 1, 11'h004, 0, 0, 11'h010); expectLookup("cnt_weak_taken", 1, 1, 11'h004);
        applyStimulus(1, 11'h010, 1, 11'h004, 0, 0, 11'h010); expectLookup("cnt_taken_1", 1, 1, 11'h004);
        applyStimulus(1, 11'h010, 1, 11'h004, 0, 0, 11'h010); expectLookup("cnt_taken_2", 1, 1, 11'h004);
        applyStimulus(1, 11'h010, 0, 11'h7ff, 0, 0, 11'h010); expectLookup("cnt_sat_high", 1, 1, 11'h004);
        look(11'h010);                                      expectLookup("one_nt_still_taken", 1, 1, 11'h004);
        applyStimulus(1, 11'h010, 0, 11'h123, 0, 0, 11'h010); expectLookup("before_second_nt", 1, 1, 11'h004);
        look(11'h010);                                      expectLookup("two_nt_not_taken", 1, 0, 11'h004);
        applyStimulus(1, 11'h010, 0, 11'h123, 0, 0, 11'h010); expectLookup("cnt_one", 1, 0, 11'h004);
        applyStimulus(1, 11'h010, 0, 11'h123, 0, 0, 11'h010); expectLookup("cnt_zero", 1, 0, 11'h004);
        applyStimulus(1, 11'h010, 1, 11'h004, 0, 0, 11'h010); expectLookup("cnt_zero_held", 1, 0, 11'h004);
        look(11'h010);                                      expectLookup("sat_low_no_wrap", 1, 0, 11'h004);
        expectStats("count_after_cnt_test", 9, 0);

        // LRU eviction
        applyStimulus(1, 11'h020, 1, 11'h100, 0, 0, 11'h020); expectLookup("alloc2_same_cycle", 0, 0, '0);
        applyStimulus(1, 11'h030, 1, 11'h200, 0, 0, 11'h020); expectLookup("alloc2_visible", 1, 1, 11'h100);
        applyStimulus(1, 11'h040, 1, 11'h300, 0, 0, 11'h030); expectLookup("alloc3_visible", 1, 1, 11'h200);
        applyStimulus(1, 11'h010, 1, 11'h004, 0, 0, 11'h040); expectLookup("alloc4_visible", 1, 1, 11'h300);
        applyStimulus(1, 11'h050, 1, 11'h500, 0, 0, 11'h010); expectLookup("hit_before_evict", 1, 1, 11'h004);
        look(11'h020);                                      expectLookup("lru_evicted", 0, 0, '0);
        look(11'h010);                                      expectLookup("mru_kept", 1, 1, 11'h004);
        look(11'h050);                                      expectLookup("new_alloc", 1, 1, 11'h500);
        look(11'h030);                                      expectLookup("other_kept", 1, 1, 11'h200);
        expectStats("count_after_lru", 14, 0);

        // taken-only allocation
        applyStimulus(1, 11'h060, 0, 11'h600, 0, 0, 11'h060); expectLookup("nt_miss_same_cycle", 0, 0, '0);
        look(11'h060);                                      expectLookup("no_alloc_nt", 0, 0, '0);
        expectStats("skip_still_counted", 15, 0);
        applyStimulus(1, 11'h070, 1, 11'h700, 0, 0, 11'h070); expectLookup("alloc7_same_cycle", 0, 0, '0);
        look(11'h030);                                      expectLookup("skip_keeps_lru", 0, 0, '0);
        look(11'h070);                                      expectLookup("alloc7_visible", 1, 1, 11'h700);
        expectStats("count_after_skip", 16, 0);

        // mispredict stats then asynchronous reset
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 11'h010, 1, 11'h004, 1, 0, 11'h010); expectLookup("mis_hit", 1, 1, 11'h004);
        end
        applyStimulus(0, '0, 0, '0, 1, 0, 11'h010);          expectLookup("after_mis", 1, 1, 11'h004);
        expectStats("mis_count", 21, 5);
        look(11'h010);                                      expectStats("bmis_ignored_no_be", 21, 5);
        @(posedge w_clk);
        #1;
        bus.w_paddr = 11'h010;
        w_rst_n = 1'b0;
        expectLookup("async_reset_lookup", 0, 0, '0);
        expectStats("async_reset_stats", 0, 0);

        // flush beats a same-cycle update
        applyStimulus(1, 11'h010, 1, 11'h004, 0, 0, 11'h010);
        w_rst_n = 1'b1;                                     expectLookup("reset_held", 0, 0, '0);
        applyStimulus(1, 11'h020, 1, 11'h100, 0, 0, 11'h010); expectLookup("realloc_after_reset", 1, 1, 11'h004);
        applyStimulus(1, 11'h030, 1, 11'h200, 0, 1, 11'h020); expectLookup("pre_flush", 1, 1, 11'h100);
        look(11'h010);                                      expectLookup("flush_clears_10", 0, 0, '0);
        look(11'h020);                                      expectLookup("flush_clears_20", 0, 0, '0);
        look(11'h030);                                      expectLookup("flush_beats_update", 0, 0, '0);

        @(negedge w_clk);
        @(negedge w_clk);
        #1;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d pending, required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
